// File: rtl/prealu_seq_pkg.sv
// rtl/prealu_seq_pkg.sv - shared op codes, preALU select encoding and FSM states for the preALU op sequencer
package prealu_seq_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/prealu_cmd_fifo.sv
// rtl/prealu_cmd_fifo.sv - synchronous command FIFO with full/empty flags, async active-low reset
module prealu_cmd_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reset flushes the FIFO by clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/prealu_op_sequencer.sv
// rtl/prealu_op_sequencer.sv - command-driven accumulator controller for the preALU; PREALU_SEQ_OVF_EN adds rsp_ovf
module prealu_op_sequencer
    import prealu_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_sel,
    input  logic [W-1:0] alu_c
`ifdef PREALU_SEQ_OVF_EN
    ,
    output logic         rsp_ovf
`endif
);

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W+1:0]  head;
    logic [1:0]    head_op;
    logic [W-1:0]  head_data;
    logic          in_exec;

    assign cmd_ready = !fifo_full;
    assign in_exec   = (state == EXEC);
    assign head_op   = head[W+1:W];
    assign head_data = head[W-1:0];

    prealu_cmd_fifo #(
        .WIDTH (W + 2),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_op, cmd_data}),
        .pop   (in_exec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ADD and SUB differ only in op[0], which maps straight onto the preALU select.
    always_comb begin
        alu_a   = acc;
        alu_b   = '0;
        alu_sel = SEL_ADD;
        if (in_exec) begin
            alu_b   = head_data;
            alu_sel = head_op[0];
        end
    end

    always_comb begin
        acc_next = '0;
        case (head_op)
            OP_ADD, OP_SUB: acc_next = alu_c;
            OP_LOAD:        acc_next = head_data;
            default:        acc_next = '0;
        endcase
    end

`ifdef PREALU_SEQ_OVF_EN
    logic ovf_next;

    always_comb begin
        ovf_next = 1'b0;
        case (head_op)
            OP_ADD:  ovf_next = (acc[W-1] == head_data[W-1]) && (alu_c[W-1] != acc[W-1]);
            OP_SUB:  ovf_next = (acc[W-1] != head_data[W-1]) && (alu_c[W-1] != acc[W-1]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_ovf <= 1'b0;
        else if (in_exec) rsp_ovf <= ovf_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= EXEC;
                end
                EXEC: begin
                    acc       <= acc_next;
                    rsp_data  <= acc_next;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Occupancy is judged before this edge's push lands.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= fifo_empty ? IDLE : EXEC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prealu_op_sequencer.sv
// tb/tb_prealu_op_sequencer.sv - self-checking bench for prealu_op_sequencer
module tb_prealu_op_sequencer;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_sel;
    logic [W-1:0] alu_c;
`ifdef PREALU_SEQ_OVF_EN
    logic         rsp_ovf;
`endif

    always #5 clk = ~clk;

    assign alu_c = alu_sel ? (alu_a - alu_b) : (alu_a + alu_b);

    prealu_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c)
`ifdef PREALU_SEQ_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] acc_before;
        logic [W-1:0] data;
        logic [1:0]   op;
        logic [W-1:0] result;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] got_q[$];
    logic         got_ovf_q[$];
    logic [W-1:0] model_acc;
    logic [W-1:0] acc_committed;
    int           n_vec = 0;
    int           n_err = 0;
    int           accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Commands execute strictly in order, so each result is known at push time.
    function automatic void model_push(input logic [1:0] op, input logic [W-1:0] d);
        exp_t e;
        int   a;
        int   b;
        int   s;
        a = $signed(model_acc);
        b = $signed(d);
        e.acc_before = model_acc;
        e.data       = d;
        e.op         = op;
        e.ovf        = 1'b0;
        case (op)
            2'b00: begin e.result = model_acc + d; s = a + b; e.ovf = (s > 7 || s < -8); end
            2'b01: begin e.result = model_acc - d; s = a - b; e.ovf = (s > 7 || s < -8); end
            2'b10: e.result = d;
            default: e.result = '0;
        endcase
        model_acc = e.result;
        exp_q.push_back(e);
    endfunction

    task automatic model_flush();
        exp_q.delete();
        model_acc     = '0;
        acc_committed = '0;
    endtask

    // One clock: observe this cycle, advance an edge, score what the edge produced.
    task automatic cycle();
        logic         push;
        logic         hs;
        logic         pv;
        logic [W-1:0] pd;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        logic         ps;
        exp_t         e;
        push = cmd_valid && cmd_ready;
        hs   = rsp_valid && rsp_ready;
        pv   = rsp_valid;
        pd   = rsp_data;
        pa   = alu_a;
        pb   = alu_b;
        ps   = alu_sel;
        if (push) begin
            model_push(cmd_op, cmd_data);
            accepted++;
        end
        @(posedge clk);
        #1;
        if (rsp_valid && (!pv || hs)) begin
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("exec_alu_a", pa, e.acc_before);
                check("exec_alu_b", pb, e.data);
                check("exec_alu_sel", ps, e.op[0]);
                check("rsp_data", rsp_data, e.result);
`ifdef PREALU_SEQ_OVF_EN
                check("rsp_ovf", rsp_ovf, e.ovf);
                got_ovf_q.push_back(rsp_ovf);
`endif
                acc_committed = e.result;
                got_q.push_back(rsp_data);
            end
        end else begin
            check("idle_alu_a", pa, acc_committed);
            check("idle_alu_b", pb, 0);
            check("idle_alu_sel", ps, 0);
        end
        if (pv && !hs) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_data", rsp_data, pd);
        end
        if (pv && hs) check("rsp_drop_after_hs", rsp_valid, 0);
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] d);
        logic took;
        took      = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 60 && !took; i++) begin
            took = cmd_ready;
            cycle();
        end
        cmd_valid = 1'b0;
        check("send_accepted", took, 1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
            else cycle();
        end
        check("drain_done", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
    endtask

    task automatic check_got(input string tag, input logic [W-1:0] v0, input logic [W-1:0] v1,
                             input logic [W-1:0] v2, input logic [W-1:0] v3, input int n);
        logic [W-1:0] want [4];
        want = '{v0, v1, v2, v3};
        check({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check(tag, got_q[i], want[i]);
        got_q.delete();
    endtask

    initial begin
        logic [1:0]   fill_op [6];
        logic [W-1:0] fill_d  [6];
        int           idx;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        model_flush();

        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs("in_reset");
        end
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            check_reset_outputs("idle");
        end

        // Latency from an idle block, then the LOAD/ADD/SUB sequence.
        rsp_ready = 1'b1;
        send(2'b10, 4'd9);
        check("lat_edge1", rsp_valid, 0);
        cycle();
        check("lat_edge2", rsp_valid, 0);
        cycle();
        check("lat_edge3", rsp_valid, 1);
        send(2'b00, 4'd7);
        send(2'b01, 4'd7);
        drain();
        check_got("seq_a", 4'd9, 4'd0, 4'd9, 4'd0, 3);

        send(2'b10, 4'd5);
        send(2'b01, 4'd2);
        send(2'b11, 4'd6);
        send(2'b00, 4'd15);
        drain();
        check_got("seq_b", 4'd5, 4'd3, 4'd0, 4'd15, 4);

        // Back-pressure: one command sits in RESP while DEPTH more fill the FIFO.
        fill_op = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        fill_d  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        rsp_ready = 1'b0;
        accepted  = 0;
        idx       = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cmd_op   = fill_op[idx];
            cmd_data = fill_d[idx];
            if (cmd_ready && idx < 5) idx++;
            cycle();
        end
        check("full_accepted", accepted, DEPTH + 1);
        check("full_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && accepted < 6; i++) begin
            cmd_op   = fill_op[idx];
            cmd_data = fill_d[idx];
            if (cmd_ready && idx < 5) idx++;
            cycle();
        end
        cmd_valid = 1'b0;
        check("full_all_accepted", accepted, 6);
        drain();
        check("full_got_count", got_q.size(), 6);
        got_q.delete();

        // Reset while a response is pending and three commands are queued.
        rsp_ready = 1'b0;
        send(2'b10, 4'd4);
        send(2'b00, 4'd1);
        send(2'b00, 4'd1);
        send(2'b00, 4'd1);
        repeat (3) cycle();
        check("pre_reset_valid", rsp_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        model_flush();
        got_q.delete();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) cycle();
        check("post_reset_quiet", got_q.size(), 0);
        send(2'b00, 4'd3);
        drain();
        check_got("post_reset", 4'd3, 4'd0, 4'd0, 4'd0, 1);

`ifdef PREALU_SEQ_OVF_EN
        got_ovf_q.delete();
        send(2'b10, 4'd7); send(2'b00, 4'd1);
        send(2'b10, 4'd8); send(2'b01, 4'd1);
        send(2'b10, 4'd3); send(2'b00, 4'd6);
        send(2'b10, 4'd2); send(2'b00, 4'd1);
        drain();
        check("ovf_count", got_ovf_q.size(), 8);
        if (got_ovf_q.size() == 8) begin
            check("ovf_7p1", got_ovf_q[1], 1);
            check("ovf_8m1", got_ovf_q[3], 1);
            check("ovf_3p6", got_ovf_q[5], 1);
            check("ovf_2p1", got_ovf_q[7], 0);
            check("ovf_load", got_ovf_q[0], 0);
        end
        check("ovf_r1", got_q[1], 4'd8);
        check("ovf_r2", got_q[3], 4'd7);
        check("ovf_r3", got_q[5], 4'd9);
        check("ovf_r4", got_q[7], 4'd3);
        got_q.delete();
`endif

        // Random traffic with random back-pressure, scored against the model.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = W'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
